// File: rtl/fb_pkg.sv
// Shared framebuffer definitions used by the write arbiter and the display block.
package fb_pkg;

    localparam int unsigned FB_HSIZE = 320;
    localparam int unsigned FB_VSIZE = 240;
    localparam int unsigned COLOR_W  = 12;
    localparam int unsigned COORD_W  = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fb_state_t;

    // One framebuffer write: column, row and colour.
    typedef struct packed {
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic [COLOR_W-1:0] color;
    } fb_pixel_t;

endpackage

// File: rtl/fb_rect_walker.sv
// Row-major cursor over an inclusive rectangle; advances one pixel per advance strobe.
module fb_rect_walker
    import fb_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               i_load,
    input  logic               i_advance,
    input  logic [COORD_W-1:0] i_x0,
    input  logic [COORD_W-1:0] i_y0,
    input  logic [COORD_W-1:0] i_x1,
    input  logic [COORD_W-1:0] i_y1,
    output logic [COORD_W-1:0] o_cx,
    output logic [COORD_W-1:0] o_cy,
    output logic               o_last
);

    logic [COORD_W-1:0] r_x0;
    logic [COORD_W-1:0] r_x1;
    logic [COORD_W-1:0] r_y1;
    logic [COORD_W-1:0] r_cx;
    logic [COORD_W-1:0] r_cy;

    // Corner latch on load, cursor step on advance with wrap to the next row.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_x0 <= '0;
            r_x1 <= '0;
            r_y1 <= '0;
            r_cx <= '0;
            r_cy <= '0;
        end else if (i_load) begin
            r_x0 <= i_x0;
            r_x1 <= i_x1;
            r_y1 <= i_y1;
            r_cx <= i_x0;
            r_cy <= i_y0;
        end else if (i_advance) begin
            if (r_cx == r_x1) begin
                r_cx <= r_x0;
                r_cy <= r_cy + COORD_W'(1);
            end else begin
                r_cx <= r_cx + COORD_W'(1);
            end
        end
    end

    assign o_cx   = r_cx;
    assign o_cy   = r_cy;
    assign o_last = (r_cx == r_x1) && (r_cy == r_y1);

endmodule

// File: rtl/fb_write_arbiter.sv
// Shares the framebuffer write port between CPU pixel stores and the rectangle-fill engine.
module fb_write_arbiter
    import fb_pkg::*;
#(
    parameter int unsigned HSIZE      = FB_HSIZE,
    parameter int unsigned VSIZE      = FB_VSIZE,
    parameter int unsigned MAX_STREAK = 4
) (
    input  logic               rclk,
    input  logic               rst,
    input  logic               px_req,
    output logic               px_ready,
    input  logic [COORD_W-1:0] px_x,
    input  logic [COORD_W-1:0] px_y,
    input  logic [COLOR_W-1:0] px_color,
    input  logic               fill_start,
    input  logic [COORD_W-1:0] fill_x0,
    input  logic [COORD_W-1:0] fill_y0,
    input  logic [COORD_W-1:0] fill_x1,
    input  logic [COORD_W-1:0] fill_y1,
    input  logic [COLOR_W-1:0] fill_color,
    output logic               fill_busy,
    output logic               fill_done,
    output logic               we,
    output logic [COORD_W-1:0] haddr,
    output logic [COORD_W-1:0] vaddr,
    output logic [COLOR_W-1:0] wdata
);

    localparam int unsigned        STREAK_W = $clog2(MAX_STREAK + 1);
    localparam logic [COORD_W-1:0] XMAX     = COORD_W'(HSIZE - 1);
    localparam logic [COORD_W-1:0] YMAX     = COORD_W'(VSIZE - 1);

    fb_state_t           r_state;
    fb_state_t           w_state_nxt;
    logic [STREAK_W-1:0] r_streak;
    logic [COLOR_W-1:0]  r_fill_color;
    logic                r_we;
    fb_pixel_t           r_wr;

    logic               w_px_gnt;
    logic               w_fill_gnt;
    logic               w_px_in;
    logic               w_start;
    logic               w_empty;
    logic               w_last;
    logic [COORD_W-1:0] w_x0;
    logic [COORD_W-1:0] w_y0;
    logic [COORD_W-1:0] w_x1;
    logic [COORD_W-1:0] w_y1;
    logic [COORD_W-1:0] w_cx;
    logic [COORD_W-1:0] w_cy;

    // Clamp the requested corners to the visible area; an inverted rectangle is empty.
    assign w_x0    = (fill_x0 > XMAX) ? XMAX : fill_x0;
    assign w_y0    = (fill_y0 > YMAX) ? YMAX : fill_y0;
    assign w_x1    = (fill_x1 > XMAX) ? XMAX : fill_x1;
    assign w_y1    = (fill_y1 > YMAX) ? YMAX : fill_y1;
    assign w_empty = (w_x0 > w_x1) || (w_y0 > w_y1);
    assign w_start = (r_state == IDLE) && fill_start;

    // Pixel stores win unless they have starved an active fill for MAX_STREAK grants.
    assign px_ready   = !((r_state == FILL) && (r_streak == STREAK_W'(MAX_STREAK)));
    assign w_px_gnt   = px_req && px_ready;
    assign w_fill_gnt = (r_state == FILL) && !w_px_gnt;
    assign w_px_in    = (px_x < COORD_W'(HSIZE)) && (px_y < COORD_W'(VSIZE));

    fb_rect_walker u_walker (
        .clk       (rclk),
        .rst       (rst),
        .i_load    (w_start),
        .i_advance (w_fill_gnt),
        .i_x0      (w_x0),
        .i_y0      (w_y0),
        .i_x1      (w_x1),
        .i_y1      (w_y1),
        .o_cx      (w_cx),
        .o_cy      (w_cy),
        .o_last    (w_last)
    );

    // State register.
    always_ff @(posedge rclk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (fill_start) begin
                    w_state_nxt = w_empty ? DONE : FILL;
                end
            end
            FILL: begin
                if (w_fill_gnt && w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Consecutive pixel grants while a fill is waiting.
    always_ff @(posedge rclk) begin
        if (rst || (r_state != FILL) || !w_px_gnt) begin
            r_streak <= '0;
        end else begin
            r_streak <= r_streak + STREAK_W'(1);
        end
    end

    // Fill colour captured with the rectangle.
    always_ff @(posedge rclk) begin
        if (rst) begin
            r_fill_color <= '0;
        end else if (w_start) begin
            r_fill_color <= fill_color;
        end
    end

    // Write register: at most one source per cycle; clipped pixels are consumed silently.
    always_ff @(posedge rclk) begin
        if (rst) begin
            r_we <= 1'b0;
            r_wr <= '0;
        end else if (w_px_gnt) begin
            r_we <= w_px_in;
            if (w_px_in) begin
                r_wr <= '{x: px_x, y: px_y, color: px_color};
            end
        end else if (w_fill_gnt) begin
            r_we <= 1'b1;
            r_wr <= '{x: w_cx, y: w_cy, color: r_fill_color};
        end else begin
            r_we <= 1'b0;
        end
    end

    assign we        = r_we;
    assign haddr     = r_wr.x;
    assign vaddr     = r_wr.y;
    assign wdata     = r_wr.color;
    assign fill_busy = (r_state != IDLE);
    assign fill_done = (r_state == DONE);

endmodule

// File: tb/tb_fb_write_arbiter.sv
// Directed and randomized bench for fb_write_arbiter against a pixel-queue reference model.
module tb_fb_write_arbiter;

    localparam int HS  = 320;
    localparam int VS  = 240;
    localparam int MAX = 4;

    logic        rclk;
    logic        rst;
    logic        px_req;
    logic        px_ready;
    logic [9:0]  px_x;
    logic [9:0]  px_y;
    logic [11:0] px_color;
    logic        fill_start;
    logic [9:0]  fill_x0;
    logic [9:0]  fill_y0;
    logic [9:0]  fill_x1;
    logic [9:0]  fill_y1;
    logic [11:0] fill_color;
    logic        fill_busy;
    logic        fill_done;
    logic        we;
    logic [9:0]  haddr;
    logic [9:0]  vaddr;
    logic [11:0] wdata;

    fb_write_arbiter #(.HSIZE(HS), .VSIZE(VS), .MAX_STREAK(MAX)) dut (
        .rclk       (rclk),
        .rst        (rst),
        .px_req     (px_req),
        .px_ready   (px_ready),
        .px_x       (px_x),
        .px_y       (px_y),
        .px_color   (px_color),
        .fill_start (fill_start),
        .fill_x0    (fill_x0),
        .fill_y0    (fill_y0),
        .fill_x1    (fill_x1),
        .fill_y1    (fill_y1),
        .fill_color (fill_color),
        .fill_busy  (fill_busy),
        .fill_done  (fill_done),
        .we         (we),
        .haddr      (haddr),
        .vaddr      (vaddr),
        .wdata      (wdata)
    );

    initial begin
        rclk = 1'b0;
        forever #5 rclk = ~rclk;
    end

    // Reference model: a pending fill is the list of pixels it still has to write.
    typedef struct {
        int x;
        int y;
        int c;
    } pix_t;

    pix_t m_q[$];
    int   m_streak = 0;
    bit   exp_we   = 1'b0;
    int   exp_h    = 0;
    int   exp_v    = 0;
    int   exp_d    = 0;
    bit   exp_busy = 1'b0;
    bit   exp_done = 1'b0;

    int n_asrt = 0;
    int n_fail = 0;
    int n_we   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_asrt++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic bit exp_ready();
        return !((m_q.size() != 0) && (m_streak == MAX));
    endfunction

    // Advance the model by one clock using the inputs currently driven.
    task automatic model_update();
        bit idle, filling, pxg, fillg, nd;
        int x0, y0, x1, y1;
        pix_t p;
        if (rst) begin
            m_q.delete();
            m_streak = 0;
            exp_we = 0; exp_h = 0; exp_v = 0; exp_d = 0;
            exp_busy = 0; exp_done = 0;
            return;
        end
        filling = (m_q.size() != 0);
        idle    = !filling && !exp_done;
        pxg     = px_req && exp_ready();
        fillg   = filling && !pxg;
        nd      = 1'b0;
        if (pxg) begin
            if (int'(px_x) < HS && int'(px_y) < VS) begin
                exp_we = 1; exp_h = int'(px_x); exp_v = int'(px_y); exp_d = int'(px_color);
            end else begin
                exp_we = 0;
            end
        end else if (fillg) begin
            p = m_q.pop_front();
            exp_we = 1; exp_h = p.x; exp_v = p.y; exp_d = p.c;
            if (m_q.size() == 0) nd = 1'b1;
        end else begin
            exp_we = 0;
        end
        m_streak = (filling && pxg) ? m_streak + 1 : 0;
        if (idle && fill_start) begin
            x0 = (int'(fill_x0) > HS - 1) ? HS - 1 : int'(fill_x0);
            y0 = (int'(fill_y0) > VS - 1) ? VS - 1 : int'(fill_y0);
            x1 = (int'(fill_x1) > HS - 1) ? HS - 1 : int'(fill_x1);
            y1 = (int'(fill_y1) > VS - 1) ? VS - 1 : int'(fill_y1);
            if (x0 > x1 || y0 > y1) begin
                nd = 1'b1;
            end else begin
                for (int y = y0; y <= y1; y++)
                    for (int x = x0; x <= x1; x++)
                        m_q.push_back('{x: x, y: y, c: int'(fill_color)});
            end
        end
        exp_done = nd;
        exp_busy = (m_q.size() != 0) || nd;
    endtask

    // One clock: inputs set after the falling edge, registered outputs checked 1ns after the rise.
    task automatic cycle();
        #1;
        if (!rst) chk("px_ready", 32'(px_ready), 32'(exp_ready()));
        model_update();
        @(posedge rclk);
        #1;
        chk("we", 32'(we), 32'(exp_we));
        chk("haddr", 32'(haddr), 32'(exp_h));
        chk("vaddr", 32'(vaddr), 32'(exp_v));
        chk("wdata", 32'(wdata), 32'(exp_d));
        chk("fill_busy", 32'(fill_busy), 32'(exp_busy));
        chk("fill_done", 32'(fill_done), 32'(exp_done));
        if (we === 1'b1) n_we++;
        @(negedge rclk);
    endtask

    task automatic rand_rect();
        int x0, y0, x1, y1;
        x0 = int'($urandom_range(0, 330));
        y0 = int'($urandom_range(0, 250));
        x1 = x0 + int'($urandom_range(0, 7)) - 1;
        y1 = y0 + int'($urandom_range(0, 5)) - 1;
        if (x1 < 0) x1 = 0;
        if (y1 < 0) y1 = 0;
        fill_x0 = 10'(x0); fill_y0 = 10'(y0);
        fill_x1 = 10'(x1); fill_y1 = 10'(y1);
        fill_color = 12'($urandom);
    endtask

    // mode 0: no pixels, 1: px_req held high, 2: random pixel traffic and stray fill_start.
    task automatic set_px(input int mode);
        px_req   = (mode == 1) ? 1'b1 : (mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
        px_x     = 10'($urandom_range(0, 330));
        px_y     = 10'($urandom_range(0, 250));
        px_color = 12'($urandom);
        if (mode == 2) begin
            fill_start = 1'($urandom_range(0, 7) == 0);
            if (fill_start) rand_rect();
        end
    endtask

    task automatic start_fill(input int x0, input int y0, input int x1, input int y1, input int c);
        fill_x0 = 10'(x0); fill_y0 = 10'(y0);
        fill_x1 = 10'(x1); fill_y1 = 10'(y1);
        fill_color = 12'(c);
        fill_start = 1'b1;
        cycle();
        fill_start = 1'b0;
    endtask

    task automatic run_idle(input int budget, input int mode);
        int n;
        n = 0;
        while ((m_q.size() != 0 || exp_done) && n < budget) begin
            set_px(mode);
            cycle();
            n++;
        end
        fill_start = 1'b0;
        px_req = 1'b0;
        n_asrt++;
        assert (n < budget) else begin
            n_fail++;
            $error("FAIL timeout: fill still busy after %0d cycles", n);
        end
    endtask

    initial begin
        rst = 1'b1; px_req = 1'b0; px_x = '0; px_y = '0; px_color = '0;
        fill_start = 1'b0; fill_x0 = '0; fill_y0 = '0; fill_x1 = '0; fill_y1 = '0;
        fill_color = '0;
        @(negedge rclk);
        cycle();
        cycle();
        rst = 1'b0;
        cycle();
        chk("reset_px_ready", 32'(px_ready), 32'd1);

        // Single in-range pixel.
        n_we = 0;
        px_req = 1'b1; px_x = 10'd5; px_y = 10'd7; px_color = 12'hABC;
        cycle();
        px_req = 1'b0;
        cycle();
        cycle();
        chk("pixel_writes", 32'(n_we), 32'd1);

        // 2x2 fill, with a second fill_start while busy that must be ignored.
        n_we = 0;
        start_fill(10, 20, 11, 21, 12'hF00);
        cycle();
        fill_x0 = 10'd50; fill_y0 = 10'd50; fill_x1 = 10'd60; fill_y1 = 10'd60;
        fill_start = 1'b1;
        cycle();
        fill_start = 1'b0;
        run_idle(50, 0);
        cycle();
        chk("fill2x2_writes", 32'(n_we), 32'd4);

        // Off-screen pixels are consumed without a write.
        n_we = 0;
        px_req = 1'b1; px_x = 10'd320; px_y = 10'd0; px_color = 12'h123;
        cycle();
        px_x = 10'd0; px_y = 10'd240;
        cycle();
        px_req = 1'b0;
        cycle();
        chk("clip_writes", 32'(n_we), 32'd0);

        // Rectangle clamped to the bottom-right corner.
        n_we = 0;
        start_fill(300, 230, 400, 300, 12'h0F0);
        run_idle(400, 0);
        chk("clamp_writes", 32'(n_we), 32'd200);

        // Empty rectangle.
        n_we = 0;
        start_fill(5, 5, 4, 5, 12'h00F);
        chk("empty_done", 32'(fill_done), 32'd1);
        run_idle(10, 0);
        cycle();
        chk("empty_writes", 32'(n_we), 32'd0);

        // Fill contended by a continuous pixel stream.
        px_req = 1'b1;
        start_fill(0, 0, 19, 9, 12'h5A5);
        run_idle(2000, 1);
        cycle();

        // Reset in the middle of a fill, then a fresh fill.
        start_fill(40, 50, 69, 53, 12'h321);
        for (int i = 0; i < 10; i++) begin
            set_px(0);
            px_req = 1'($urandom_range(0, 1));
            cycle();
        end
        px_req = 1'b0;
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        chk("abort_busy", 32'(fill_busy), 32'd0);
        for (int i = 0; i < 5; i++) cycle();
        n_we = 0;
        start_fill(7, 8, 9, 9, 12'h777);
        run_idle(100, 0);
        chk("refill_writes", 32'(n_we), 32'd6);

        // Randomized fills under random pixel traffic.
        for (int k = 0; k < 30; k++) begin
            rand_rect();
            set_px(0);
            px_req = 1'($urandom_range(0, 1));
            fill_start = 1'b1;
            cycle();
            fill_start = 1'b0;
            run_idle(5000, 2);
            for (int i = 0; i < int'($urandom_range(0, 3)); i++) begin
                set_px(0);
                px_req = 1'($urandom_range(0, 1));
                cycle();
            end
        end
        px_req = 1'b0;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
